// File: rtl/ring_freq_meter.sv
// ring_freq_meter: gated frequency meter for one ring-oscillator Gray counter.
//
// The free-running Gray count from the ring domain is synchronised into i_clk,
// converted to binary, and its per-cycle deltas are summed over a window of
// pGATE i_clk cycles. The summed result saturates at all-ones. The result is
// also readable a byte at a time for the 8-bit LED/scan output path.
//
// Optional feature: define RING_FREQ_MINMAX_EN to track the min/max result
// since reset (readable on byte selects 4..7). Otherwise selects 4..7 read 0.
//
// Ports:
//   i_clk       sample/system clock
//   i_rst       synchronous, active-high reset
//   i_gray      asynchronous Gray count from the ring domain
//   i_start     pulse, begins a measurement when idle
//   i_cont      level, auto-restart after each window
//   i_byte_sel  readout select for o_byte
//   o_busy      measurement in progress
//   o_valid     o_count holds a completed result
//   o_ovf       last result saturated
//   o_count     last result (ring edges counted in the window)
//   o_byte      registered byte readout, 1-cycle latency from i_byte_sel
module ring_freq_meter #(
    parameter int unsigned pCNT_W = 16,
    parameter int unsigned pACC_W = 24,
    parameter int unsigned pGATE  = 1000,
    parameter int unsigned pSYNC  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [pCNT_W-1:0] i_gray,
    input  logic              i_start,
    input  logic              i_cont,
    input  logic [2:0]        i_byte_sel,
    output logic              o_busy,
    output logic              o_valid,
    output logic              o_ovf,
    output logic [pACC_W-1:0] o_count,
    output logic [7:0]        o_byte
);

    localparam int unsigned GATE_W = $clog2(pGATE);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StGate = 2'd2,
        StDone = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic [pSYNC-1:0][pCNT_W-1:0]   sync_q;
    logic [pCNT_W-1:0]              g_bin;
    logic [pCNT_W-1:0]              prev_q, prev_d;
    logic [pCNT_W-1:0]              delta;
    logic [pACC_W:0]                sum;
    logic [pACC_W-1:0]              acc_q, acc_d;
    logic [GATE_W-1:0]              gate_q, gate_d;
    logic                           sat_q, sat_d;
    logic [pACC_W-1:0]              count_q, count_d;
    logic                           valid_q, valid_d;
    logic                           ovf_q, ovf_d;
    logic [7:0]                     byte_q, byte_d;
    logic [23:0]                    count_lo;
    logic                           busy;

    // Synchroniser: index 0 is the first flop, pSYNC-1 the last.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[pSYNC-2:0], i_gray};
        end
    end

    // Gray to binary: bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        g_bin = '0;
        for (int i = 0; i < pCNT_W; i++) begin
            g_bin[i] = ^(sync_q[pSYNC-1] >> i);
        end
    end

    // Modular delta absorbs wraps of the ring counter.
    assign delta = g_bin - prev_q;
    assign sum   = {1'b0, acc_q} + {{(pACC_W + 1 - pCNT_W){1'b0}}, delta};

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        acc_d   = acc_q;
        gate_d  = gate_q;
        sat_d   = sat_q;
        count_d = count_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) state_d = StArm;
            end
            StArm: begin
                prev_d  = g_bin;
                acc_d   = '0;
                sat_d   = 1'b0;
                gate_d  = GATE_W'(pGATE - 1);
                valid_d = 1'b0;
                ovf_d   = 1'b0;
                state_d = StGate;
            end
            StGate: begin
                prev_d = g_bin;
                if (sum[pACC_W]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[pACC_W-1:0];
                end
                if (gate_q == '0) begin
                    state_d = StDone;
                end else begin
                    gate_d = gate_q - 1'b1;
                end
            end
            StDone: begin
                count_d = acc_q;
                ovf_d   = sat_q;
                valid_d = 1'b1;
                state_d = i_cont ? StArm : StIdle;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            prev_q  <= '0;
            acc_q   <= '0;
            gate_q  <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            acc_q   <= acc_d;
            gate_q  <= gate_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            byte_q  <= byte_d;
        end
    end

`ifdef RING_FREQ_MINMAX_EN
    logic [pACC_W-1:0] min_q, max_q;
    logic              have_q;
    logic [15:0]       min_lo, max_lo;

    // First completed window loads both; later windows widen the range.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            min_q  <= '0;
            max_q  <= '0;
            have_q <= 1'b0;
        end else if (state_q == StDone) begin
            if (!have_q || acc_q < min_q) min_q <= acc_q;
            if (!have_q || acc_q > max_q) max_q <= acc_q;
            have_q <= 1'b1;
        end
    end

    assign min_lo = 16'(min_q);
    assign max_lo = 16'(max_q);
`endif

    assign busy     = (state_q != StIdle);
    assign count_lo = 24'(count_q);

    always_comb begin
        byte_d = 8'h00;
        unique case (i_byte_sel)
            3'd0: byte_d = count_lo[7:0];
            3'd1: byte_d = count_lo[15:8];
            3'd2: byte_d = count_lo[23:16];
            3'd3: byte_d = {ovf_q, valid_q, busy, state_q, 3'b000};
`ifdef RING_FREQ_MINMAX_EN
            3'd4: byte_d = min_lo[7:0];
            3'd5: byte_d = min_lo[15:8];
            3'd6: byte_d = max_lo[7:0];
            3'd7: byte_d = max_lo[15:8];
`else
            3'd4, 3'd5, 3'd6, 3'd7: byte_d = 8'h00;
`endif
            default: byte_d = 8'h00;
        endcase
    end

    assign o_busy  = busy;
    assign o_valid = valid_q;
    assign o_ovf   = ovf_q;
    assign o_count = count_q;
    assign o_byte  = byte_q;

endmodule
